// File: rtl/mul_8bits.sv
// mul_8bits_ctrl: sequential 8x8 -> 16-bit unsigned shift-add multiplier.
// One adder_8bits is reused over 8 RUN cycles, one multiplier bit per cycle.
// Optional feature macro: MUL_BYPASS_EN. When defined, operands of 0x00/0x01
// skip the RUN phase and land in DONE straight from the accepting edge.
//
// Handshake contract (both sides): a transfer happens on a rising clk_i edge
// where valid and ready are both high. A producer may present valid at any
// time; ready depends only on internal state, never on the valid input.
// out_valid_o, once raised, stays high with product_o stable until the
// consumer takes it (or reset).

module adder_8bits (
  input  logic [7:0] in1_i,
  input  logic [7:0] in2_i,
  output logic [7:0] sum_o,
  output logic       carry_o
);
  // Plain ripple add; carry is the 9th bit of the sum.
  assign {carry_o, sum_o} = {1'b0, in1_i} + {1'b0, in2_i};
endmodule

module mul_8bits_ctrl #(
  parameter int OPW   = 8,   // must stay 8 to match adder_8bits
  parameter int CNT_W = 3,   // step counter, counts 0..OPW-1
  parameter int OCW   = 16   // delivered-products counter width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OPW-1:0]   a_i,
  input  logic [OPW-1:0]   b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2*OPW-1:0] product_o,
  output logic             busy_o,
  output logic [OCW-1:0]   op_count_o,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [OPW-1:0]   r_a;
  logic [OPW-1:0]   r_hi;
  logic [OPW-1:0]   r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic [OCW-1:0]   r_op_count;

  logic [OPW-1:0]   w_addend;
  logic [OPW-1:0]   w_sum;
  logic             w_carry;
  logic             w_accept;
  logic             w_take;
  logic             w_last_step;
  logic             w_bypass;
  logic [OPW-1:0]   w_byp_lo;

  assign w_accept    = (r_state == S_IDLE) && in_valid_i;
  assign w_take      = (r_state == S_DONE) && out_ready_i;
  assign w_last_step = (r_cnt == CNT_W'(OPW - 1));

`ifdef MUL_BYPASS_EN
  // Trivial operands: product is 0, or the other operand zero-extended,
  // which always fits in the low half.
  logic w_a_zero, w_b_zero, w_a_one, w_b_one;
  assign w_a_zero = (a_i == '0);
  assign w_b_zero = (b_i == '0);
  assign w_a_one  = (a_i == OPW'(1));
  assign w_b_one  = (b_i == OPW'(1));
  assign w_bypass = w_a_zero || w_b_zero || w_a_one || w_b_one;
  assign w_byp_lo = (w_a_zero || w_b_zero) ? '0 : (w_a_one ? b_i : a_i);
`else
  assign w_bypass = 1'b0;
  assign w_byp_lo = '0;
`endif

  // Partial product: add multiplicand to the high half when the current
  // multiplier bit (LO[0]) is set.
  assign w_addend = r_lo[0] ? r_a : '0;

  adder_8bits u_adder (
    .in1_i   (r_hi),
    .in2_i   (w_addend),
    .sum_o   (w_sum),
    .carry_o (w_carry)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next_state = w_bypass ? S_DONE : S_RUN;
      S_RUN:   if (w_last_step) w_next_state = S_DONE;
      S_DONE:  if (out_ready_i) w_next_state = S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  // Output decode; product is only presented in DONE.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    product_o   = '0;
    case (r_state)
      S_IDLE: in_ready_o = 1'b1;
      S_RUN:  busy_o     = 1'b1;
      S_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        product_o   = {r_hi, r_lo};
      end
      default: in_ready_o = 1'b0;
    endcase
  end

  // Datapath: load operands, shift-add one bit per RUN cycle, count takes.
  // The 17-bit {carry, sum, LO} is shifted right as one value each step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_op_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= a_i;
            r_hi  <= '0;
            r_lo  <= w_bypass ? w_byp_lo : b_i;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_hi  <= {w_carry, w_sum[OPW-1:1]};
          r_lo  <= {w_sum[0], r_lo[OPW-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          if (w_take) r_op_count <= r_op_count + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign op_count_o  = r_op_count;
  assign state_dbg_o = r_state;

endmodule

// File: tb/tb_mul_8bits_ctrl.sv
// Bench for mul_8bits_ctrl: vector table, hand-written reset / hold /
// ignore / wrap sequences, then random operands against a * b.
// Honours MUL_BYPASS_EN the same way the design does (expected latency).
// Inputs change and outputs are sampled on the falling edge.

module tb_mul_8bits_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] product_o;
  logic        busy_o;
  logic [15:0] op_count_o;
  logic [1:0]  state_dbg_o;

  int          checks;
  int          failures;
  logic [15:0] exp_q[$];
  int          lat_q[$];
  logic [15:0] exp_cnt;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  mul_8bits_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .product_o   (product_o),
    .busy_o      (busy_o),
    .op_count_o  (op_count_o),
    .state_dbg_o (state_dbg_o)
  );

  // Clock and watchdog.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Edges from the accepting edge until out_valid_o is seen.
  function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_BYPASS_EN
    if (a <= 8'd1 || b <= 8'd1) return 0;
`endif
    return 8;
  endfunction

  // Present operands at a falling edge; returns one falling edge after accept.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod);
    int n = 0;
    while (!in_ready_o && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    check("in_ready_before_send", {31'd0, in_ready_o}, 32'd1);
    in_valid_i = 1'b1;
    a_i        = a;
    b_i        = b;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    exp_q.push_back(prod);
    lat_q.push_back(exp_latency(a, b));
  endtask

  // Wait for the product, hold the consumer off for 'hold' cycles, then take.
  task automatic wait_result(input int hold, input int pre);
    int          lat = pre;
    logic [15:0] exp_p;
    int          exp_l;
    exp_p = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    while (!out_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    check("latency", lat, exp_l);
    check("product", {16'd0, product_o}, {16'd0, exp_p});
    check("busy_in_done", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("valid_held", {31'd0, out_valid_o}, 32'd1);
      check("product_held", {16'd0, product_o}, {16'd0, exp_p});
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    exp_cnt     = exp_cnt + 16'd1;
    check("valid_after_take", {31'd0, out_valid_o}, 32'd0);
    check("op_count", {16'd0, op_count_o}, {16'd0, exp_cnt});
    check("ready_after_take", {31'd0, in_ready_o}, 32'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    checks      = 0;
    failures    = 0;
    exp_cnt     = 16'd0;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    a_i         = 8'h00;
    b_i         = 8'h00;

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 0};
    vecs[1] = '{8'h0D, 8'h0B, 16'h008F, 5};
    vecs[2] = '{8'h00, 8'h5A, 16'h0000, 0};
    vecs[3] = '{8'h01, 8'h37, 16'h0037, 1};
    vecs[4] = '{8'h12, 8'h34, 16'h03A8, 2};
    vecs[5] = '{8'hFF, 8'h01, 16'h00FF, 0};
    vecs[6] = '{8'hAA, 8'h55, 16'h3872, 3};
    vecs[7] = '{8'h80, 8'h00, 16'h0000, 0};

    // Reset values.
    repeat (2) @(negedge clk_i);
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_product", {16'd0, product_o}, 32'd0);
    check("rst_op_count", {16'd0, op_count_o}, 32'd0);
    check("rst_state_idle", {30'd0, state_dbg_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Vector table.
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].prod);
      wait_result(vecs[i].hold, 0);
    end

    // Reset during RUN at cnt=4, with in_valid held through reset.
    send(8'h12, 8'h34, 16'h03A8);
    repeat (4) @(negedge clk_i);
    in_valid_i = 1'b1;
    a_i        = 8'h80;
    b_i        = 8'h02;
    rst_i      = 1'b1;
    #1;
    check("midrun_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("midrun_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("midrun_rst_busy", {31'd0, busy_o}, 32'd0);
    check("midrun_rst_product", {16'd0, product_o}, 32'd0);
    check("midrun_rst_op_count", {16'd0, op_count_o}, 32'd0);
    exp_q.delete();
    lat_q.delete();
    exp_cnt = 16'd0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check("accept_after_rst", {31'd0, busy_o || out_valid_o}, 32'd1);
    exp_q.push_back(16'h0100);
    lat_q.push_back(exp_latency(8'h80, 8'h02));
    wait_result(0, 0);

    // New operands and a stray out_ready during RUN must be ignored.
    send(8'h23, 8'h45, 16'h096F);
    in_valid_i  = 1'b1;
    a_i         = 8'hFF;
    b_i         = 8'hFF;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("busy_while_ignoring", {31'd0, busy_o}, 32'd1);
    in_valid_i = 1'b0;
    wait_result(2, 5);

    // Op counter wrap from 0xFFFF.
    force dut.r_op_count = 16'hFFFF;
    @(negedge clk_i);
    release dut.r_op_count;
    @(negedge clk_i);
    check("op_count_preload", {16'd0, op_count_o}, 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    send(8'h03, 8'h05, 16'h000F);
    wait_result(0, 0);
    check("op_count_wrapped", {16'd0, op_count_o}, 32'd0);

    // Random operands against plain multiplication.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 6 == 0) rb = 8'($urandom_range(0, 1));
      send(ra, rb, 16'(ra) * 16'(rb));
      wait_result($urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
